// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// cache_pkg : shared widths, states and typedefs for the cache memory path
// Rev 1.0
// ============================================================================
package cache_pkg;

   localparam int LINE_W   = 256;
   localparam int BURST_W  = 64;
   localparam int BEATS    = LINE_W / BURST_W;
   localparam int ADDR_W   = 32;
   localparam int OFFSET_W = $clog2(LINE_W / 8);
   localparam int CNT_W    = $clog2(BEATS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } adaptor_state_t;

   // Beat-indexed line view: element k occupies bits 64k+63:64k
   typedef logic [BEATS-1:0][BURST_W-1:0] line_t;
   typedef logic [BURST_W-1:0]            beat_t;
   typedef logic [ADDR_W-1:0]             addr_t;
   typedef logic [CNT_W-1:0]              beat_idx_t;

   localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

endpackage
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// cacheline_adaptor : 256-bit cache line <-> 4 x 64-bit memory burst bridge
// Rev 1.0
// ============================================================================
module cacheline_adaptor
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   adaptor_state_t state, state_next;
   beat_idx_t      cnt;
   line_t          fill_line;
   line_t          wb_line;
   addr_t          addr;
   logic           last_beat;

   assign last_beat = resp_i && (cnt == LAST_BEAT);

   // Fill and write-back buffers are kept apart so a write-back never disturbs
   // the last filled line presented on line_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         fill_line <= '0;
         wb_line   <= '0;
         addr      <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (write_i) begin
                  wb_line <= line_i;
                  addr    <= {address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                  cnt     <= '0;
               end else if (read_i) begin
                  addr    <= {address_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                  cnt     <= '0;
               end
            end
            RD: begin
               if (resp_i) begin
                  fill_line[cnt] <= burst_i;
                  cnt            <= cnt + beat_idx_t'(1);
               end
            end
            WR: begin
               if (resp_i) begin
                  cnt <= cnt + beat_idx_t'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      read_o     = 1'b0;
      write_o    = 1'b0;
      resp_o     = 1'b0;
      case (state)
         IDLE: begin
            if (write_i) begin
               state_next = WR;
            end else if (read_i) begin
               state_next = RD;
            end
         end
         RD: begin
            read_o = 1'b1;
            if (last_beat) begin
               state_next = DONE;
            end
         end
         WR: begin
            write_o = 1'b1;
            if (last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            resp_o     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign line_o    = fill_line;
   assign burst_o   = wb_line[cnt];
   assign address_o = addr;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// tb_cacheline_adaptor : randomized scoreboard bench for cacheline_adaptor
// Rev 1.0
// ============================================================================
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] line_i = '0;
   logic [255:0] line_o;
   logic [31:0]  address_i = '0;
   logic         read_i = 1'b0;
   logic         write_i = 1'b0;
   logic         resp_o;
   logic [63:0]  burst_i = '0;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i = 1'b0;

   cacheline_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit           wr;
      logic [255:0] line;
      int           cyc;
   } exp_t;

   exp_t        exq[$];
   logic [63:0] wq[$];
   logic [31:0] exp_addr = '0;
   int          exp_mode = 0;   // 0 none, 1 read burst, 2 write burst
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
      return l;
   endfunction

   // Monitor: compares DUT activity against what the stimulus predicted
   always @(negedge clk) begin
      if (!rst) begin
         if (read_o) chk("read_o_when_not_reading", 256'(exp_mode == 1), 256'(1));
         if (write_o) chk("write_o_when_not_writing", 256'(exp_mode == 2), 256'(1));
         if (read_o || write_o) chk("address_o", 256'(address_o), 256'(exp_addr));
         if (write_o) begin
            if (wq.size() == 0) chk("write_beat_unexpected", 256'(1), 256'(0));
            else if (resp_i) chk("burst_o_sampled", 256'(burst_o), 256'(wq.pop_front()));
            else chk("burst_o_held", 256'(burst_o), 256'(wq[0]));
         end
         if (resp_o) begin
            chk("busy_in_resp_cycle", 256'({read_o, write_o}), 256'(0));
            if (exq.size() == 0) begin
               chk("spurious_resp", 256'(1), 256'(0));
            end else begin
               exp_t e;
               e = exq.pop_front();
               chk("resp_cycle", 256'(cyc), 256'(e.cyc));
               if (!e.wr) chk("fill_line", line_o, e.line);
            end
         end
      end
   end

   // One cache transaction; g* are idle cycles inserted before each beat.
   task automatic xfer(input bit wr, input bit both, input logic [31:0] a,
                       input logic [255:0] d, input int g0, input int g1,
                       input int g2, input int g3, input bit done_pulse);
      int g[4];
      int tot;
      int acc;
      g = '{g0, g1, g2, g3};
      tot = g0 + g1 + g2 + g3;
      exp_addr = {a[31:5], 5'b0};
      exp_mode = wr ? 2 : 1;
      if (wr) for (int k = 0; k < 4; k++) wq.push_back(d[64*k +: 64]);
      address_i = a;
      write_i   = wr;
      read_i    = !wr || both;
      line_i    = wr ? d : rand_line();
      @(posedge clk); #1;
      acc = cyc;
      exq.push_back('{wr, d, acc + 4 + tot});
      line_i = rand_line();
      for (int k = 0; k < 4; k++) begin
         resp_i = 1'b0;
         repeat (g[k]) begin
            burst_i = {$urandom, $urandom};
            @(posedge clk); #1;
         end
         resp_i  = 1'b1;
         burst_i = wr ? {$urandom, $urandom} : d[64*k +: 64];
         @(posedge clk); #1;
      end
      resp_i  = done_pulse;
      burst_i = {$urandom, $urandom};
      @(posedge clk); #1;
      resp_i   = 1'b0;
      read_i   = 1'b0;
      write_i  = 1'b0;
      exp_mode = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_line_o"}, line_o, 256'(0));
      chk({tag, "_burst_o"}, 256'(burst_o), 256'(0));
      chk({tag, "_address_o"}, 256'(address_o), 256'(0));
      chk({tag, "_rwr"}, 256'({read_o, write_o, resp_o}), 256'(0));
   endtask

   initial begin
      logic [255:0] l;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back read, address offset stripped to line boundary
      l = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
      xfer(1'b0, 1'b0, 32'h0000_1234, l, 0, 0, 0, 0, 1'b0);
      chk("line_o_after_read", line_o, l);
      chk("address_o_aligned", 256'(address_o), 256'(32'h0000_1220));

      // Write with gapped handshake 1,0,1,0,0,1,1
      l = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
      xfer(1'b1, 1'b0, 32'h8000_00FF, l, 0, 1, 2, 0, 1'b0);
      chk("line_o_kept_over_write",
          line_o, {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}});

      // Read and write both requested: write path wins
      xfer(1'b1, 1'b1, 32'h0000_0040, rand_line(), 0, 0, 1, 0, 1'b0);

      // Reset after two read beats
      exp_addr = 32'h0000_2000;
      exp_mode = 1;
      address_i = 32'h0000_2000;
      read_i = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         resp_i  = 1'b1;
         burst_i = 64'hDEAD_0000_0000_0000 | 64'(k);
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      read_i = 1'b0;
      rst    = 1'b1;
      @(posedge clk); #1;
      exp_mode = 0;
      check_all_zero("midburst_reset");
      rst = 1'b0;
      @(posedge clk); #1;
      l = rand_line();
      xfer(1'b0, 1'b0, 32'h0000_3010, l, 0, 0, 0, 0, 1'b0);
      chk("line_after_reset_read", line_o, l);

      // resp_i during DONE with read_i held, then resp_i pulses in IDLE
      xfer(1'b0, 1'b0, 32'hABCD_EF01, rand_line(), 1, 0, 0, 2, 1'b1);
      for (int i = 0; i < 4; i++) begin
         resp_i = i[0];
         @(posedge clk); #1;
         chk("idle_quiet", 256'({read_o, write_o, resp_o}), 256'(0));
      end
      resp_i = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rand_line(),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      #1;
      chk("pending_responses", 256'(exq.size()), 256'(0));
      chk("pending_write_beats", 256'(wq.size()), 256'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog actual=timeout required=completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
